// File: rtl/e203_flush_pkg.sv
// Shared types and constants for the EXU flush arbiter.
package e203_flush_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } flush_state_e;

    localparam int SRC_EXCP = 0;
    localparam int SRC_BRCH = 1;
    localparam int SRC_DBG  = 2;

    localparam int DEF_N_SRC = 3;
    localparam int DEF_PC_W  = 32;
    localparam int DEF_CNT_W = 16;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/e203_prio_pick.sv
// Fixed-priority picker: lowest set index wins. Also reports the mask of
// all positions strictly above the winner.
module e203_prio_pick
    import e203_flush_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC
) (
    input  logic [N_SRC-1:0]        i_req,
    output logic                    o_valid,
    output logic [N_SRC-1:0]        o_onehot,
    output logic [idw(N_SRC)-1:0]   o_idx,
    output logic [N_SRC-1:0]        o_above
);

    localparam int ID_W = idw(N_SRC);

    logic w_found;

    // Scan upward; once a winner is found every later bit lands in o_above.
    always_comb begin
        w_found  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        o_above  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!w_found && i_req[i]) begin
                o_onehot[i] = 1'b1;
                o_idx       = ID_W'(i);
                w_found     = 1'b1;
            end else begin
                o_above[i]  = w_found;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/e203_exu_flush_arb.sv
// Commit-stage flush arbiter: latches one winner's flush-PC operands and
// holds them on the IFU flush interface until acknowledged.
module e203_exu_flush_arb
    import e203_flush_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC,
    parameter int PC_W  = DEF_PC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC-1:0]          src_req,
    input  logic [N_SRC*PC_W-1:0]     src_op1,
    input  logic [N_SRC*PC_W-1:0]     src_op2,
    input  logic [N_SRC-1:0]          src_kill_younger,
    output logic [N_SRC-1:0]          src_ack,
    output logic                      pipe_flush_req,
    output logic [PC_W-1:0]           pipe_flush_add_op1,
    output logic [PC_W-1:0]           pipe_flush_add_op2,
    input  logic                      pipe_flush_ack,
    output logic                      flush_pulse,
    output logic [idw(N_SRC)-1:0]     flush_src_id,
    output logic                      flush_busy,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int ID_W = idw(N_SRC);

    flush_state_e       r_state;
    flush_state_e       w_state_nxt;

    logic               w_pick_vld;
    logic [N_SRC-1:0]   w_pick_oh;
    logic [ID_W-1:0]    w_pick_idx;
    logic [N_SRC-1:0]   w_pick_above;
    logic               w_kill_sel;
    logic [PC_W-1:0]    w_op1;
    logic [PC_W-1:0]    w_op2;
    logic               w_latch;
    logic               w_accept;

    logic [PC_W-1:0]    r_op1;
    logic [PC_W-1:0]    r_op2;
    logic [ID_W-1:0]    r_id;
    logic [N_SRC-1:0]   r_win_oh;
    logic [N_SRC-1:0]   r_kill_mask;
    logic [N_SRC-1:0]   r_ack;
    logic               r_req;
    logic               r_pulse;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;

    e203_prio_pick #(
        .N_SRC    (N_SRC)
    ) u_pick (
        .i_req    (src_req),
        .o_valid  (w_pick_vld),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_above  (w_pick_above)
    );

    assign w_kill_sel = |(src_kill_younger & w_pick_oh);
    assign w_latch    = (r_state == IDLE) && w_pick_vld;
    assign w_accept   = (r_state == HOLD) && pipe_flush_ack;

    // One-hot AND-OR mux of the winning source's operands.
    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_op1 = w_op1 | (src_op1[i*PC_W +: PC_W] & {PC_W{w_pick_oh[i]}});
            w_op2 = w_op2 | (src_op2[i*PC_W +: PC_W] & {PC_W{w_pick_oh[i]}});
        end
    end

    // Next-state logic; acks outside HOLD are ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (pipe_flush_ack) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            DRAIN:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, latched winner and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op1       <= '0;
            r_op2       <= '0;
            r_id        <= '0;
            r_win_oh    <= '0;
            r_kill_mask <= '0;
            r_ack       <= '0;
            r_req       <= 1'b0;
            r_pulse     <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == HOLD);
            r_busy  <= (w_state_nxt != IDLE);
            r_pulse <= w_accept;
            // Kill-acks only reach younger sources still requesting at accept time.
            r_ack   <= w_accept ? (r_win_oh | (r_kill_mask & src_req)) : '0;
            if (w_latch) begin
                r_op1       <= w_op1;
                r_op2       <= w_op2;
                r_id        <= w_pick_idx;
                r_win_oh    <= w_pick_oh;
                r_kill_mask <= w_kill_sel ? w_pick_above : '0;
            end
            if (w_accept && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1'b1);
            end
        end
    end

    assign src_ack            = r_ack;
    assign pipe_flush_req     = r_req;
    assign pipe_flush_add_op1 = r_op1;
    assign pipe_flush_add_op2 = r_op2;
    assign flush_pulse        = r_pulse;
    assign flush_src_id       = r_id;
    assign flush_busy         = r_busy;
    assign flush_cnt          = r_cnt;

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Directed and randomized bench for e203_exu_flush_arb against a
// transaction-level reference model.
module tb_e203_exu_flush_arb;

    localparam int N       = 3;
    localparam int PW      = 32;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            t_rst;
    logic [N-1:0]    t_req;
    logic [N*PW-1:0] t_op1;
    logic [N*PW-1:0] t_op2;
    logic [N-1:0]    t_kill;
    logic            t_ack;

    logic [N-1:0]    src_ack;
    logic            pipe_flush_req;
    logic [PW-1:0]   pipe_flush_add_op1;
    logic [PW-1:0]   pipe_flush_add_op2;
    logic            flush_pulse;
    logic [1:0]      flush_src_id;
    logic            flush_busy;
    logic [CW-1:0]   flush_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // reference model: a pending flush (or none), a drain flag, a counter
    bit          m_hold, m_drain, m_kill;
    int          m_id, m_cnt;
    logic [31:0] m_op1, m_op2;
    logic [N-1:0] e_ack;
    bit          e_pulse;
    int          served[$];

    e203_exu_flush_arb #(.N_SRC(N), .PC_W(PW), .CNT_W(CW)) dut (
        .clk                (clk),
        .rst                (t_rst),
        .src_req            (t_req),
        .src_op1            (t_op1),
        .src_op2            (t_op2),
        .src_kill_younger   (t_kill),
        .src_ack            (src_ack),
        .pipe_flush_req     (pipe_flush_req),
        .pipe_flush_add_op1 (pipe_flush_add_op1),
        .pipe_flush_add_op2 (pipe_flush_add_op2),
        .pipe_flush_ack     (t_ack),
        .flush_pulse        (flush_pulse),
        .flush_src_id       (flush_src_id),
        .flush_busy         (flush_busy),
        .flush_cnt          (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [N-1:0] nack;
        bit npulse;
        nack   = '0;
        npulse = 1'b0;
        if (t_rst) begin
            m_hold = 1'b0; m_drain = 1'b0; m_kill = 1'b0;
            m_id = 0; m_cnt = 0; m_op1 = '0; m_op2 = '0;
        end else if (m_hold) begin
            if (t_ack) begin
                nack[m_id] = 1'b1;
                if (m_kill) begin
                    for (int j = m_id + 1; j < N; j++) begin
                        if (t_req[j]) nack[j] = 1'b1;
                    end
                end
                npulse = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_hold  = 1'b0;
                m_drain = 1'b1;
                served.push_back(m_id);
            end
        end else if (m_drain) begin
            m_drain = 1'b0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (t_req[j]) begin
                    m_id   = j;
                    m_op1  = t_op1[j*PW +: PW];
                    m_op2  = t_op2[j*PW +: PW];
                    m_kill = t_kill[j];
                    m_hold = 1'b1;
                    break;
                end
            end
        end
        e_ack   = nack;
        e_pulse = npulse;
        @(posedge clk);
        #1;
        check("pipe_flush_req", pipe_flush_req, m_hold);
        check("op1", pipe_flush_add_op1, m_op1);
        check("op2", pipe_flush_add_op2, m_op2);
        check("src_ack", src_ack, e_ack);
        check("flush_pulse", flush_pulse, e_pulse);
        check("flush_src_id", flush_src_id, m_id);
        check("flush_busy", flush_busy, m_hold | m_drain);
        check("flush_cnt", flush_cnt, m_cnt);
    endtask

    task automatic do_reset();
        t_rst = 1'b1; t_ack = 1'b0;
        tick();
        t_rst = 1'b0;
    endtask

    task automatic set_src(input int j, input logic [31:0] a, input logic [31:0] b, input bit k);
        t_op1[j*PW +: PW] = a;
        t_op2[j*PW +: PW] = b;
        t_kill[j] = k;
        t_req[j]  = 1'b1;
    endtask

    // wait for HOLD, keep it for hold_cyc cycles, ack, and let acked sources drop
    task automatic serve(input int hold_cyc);
        int guard = 0;
        while (!m_hold && guard < 20) begin
            tick();
            guard++;
        end
        check("serve_hold_reached", pipe_flush_req, 1'b1);
        repeat (hold_cyc - 1) tick();
        t_ack = 1'b1;
        tick();
        t_ack = 1'b0;
        t_req = t_req & ~e_ack;
    endtask

    initial begin
        t_rst = 1'b0; t_req = '0; t_op1 = '0; t_op2 = '0; t_kill = '0; t_ack = 1'b0;
        m_hold = 1'b0; m_drain = 1'b0; m_kill = 1'b0; m_id = 0; m_cnt = 0;
        m_op1 = '0; m_op2 = '0;

        // reset state
        do_reset();
        check("rst_req", pipe_flush_req, 1'b0);
        check("rst_cnt", flush_cnt, 2'd0);

        // single branch flush, acked in the third HOLD cycle
        set_src(1, 32'h8000_0100, 32'h0000_0004, 1'b0);
        serve(3);
        check("br_ack", src_ack, 3'b010);
        check("br_pulse", flush_pulse, 1'b1);
        check("br_id", flush_src_id, 2'd1);
        check("br_cnt", flush_cnt, 2'd1);
        tick();
        tick();
        check("br_idle", flush_busy, 1'b0);

        // simultaneous requests without kill: serviced 0,1,2
        do_reset();
        served.delete();
        set_src(0, 32'h0000_1000, 32'h10, 1'b0);
        set_src(1, 32'h0000_2000, 32'h20, 1'b0);
        set_src(2, 32'h0000_3000, 32'h30, 1'b0);
        repeat (3) serve(1);
        tick();
        check("sim_n", served.size(), 3);
        for (int k = 0; k < 3 && k < served.size(); k++) check("sim_order", served[k], k);
        check("sim_cnt", flush_cnt, 2'd3);

        // exception kills branch in the same ack
        do_reset();
        set_src(0, 32'hA000_0000, 32'h8, 1'b1);
        set_src(1, 32'hB000_0000, 32'hC, 1'b0);
        check("kill_dummy_req_low", pipe_flush_req, 1'b0);
        tick();
        check("kill_op1", pipe_flush_add_op1, 32'hA000_0000);
        serve(2);
        check("kill_ack", src_ack, 3'b011);
        check("kill_cnt", flush_cnt, 2'd1);
        repeat (3) tick();
        check("kill_no_refl", pipe_flush_req, 1'b0);

        // no preemption; ack in IDLE ignored beforehand
        do_reset();
        t_ack = 1'b1;
        repeat (2) tick();
        t_ack = 1'b0;
        set_src(2, 32'hD000_0000, 32'h44, 1'b0);
        tick();
        set_src(0, 32'hE000_0000, 32'h55, 1'b0);
        repeat (3) tick();
        check("np_op1", pipe_flush_add_op1, 32'hD000_0000);
        serve(1);
        check("np_ack", src_ack, 3'b100);
        tick();
        tick();
        check("np_id", flush_src_id, 2'd0);
        check("np_op", pipe_flush_add_op1, 32'hE000_0000);
        serve(1);
        tick();

        // source dropping its request in HOLD still gets acked
        set_src(1, 32'h1234_5678, 32'h4, 1'b0);
        tick();
        t_req[1] = 1'b0;
        serve(2);
        check("drop_ack", src_ack, 3'b010);
        tick();

        // reset mid-HOLD, then re-arbitration of the held request
        set_src(1, 32'h2222_0000, 32'h4, 1'b0);
        tick();
        t_rst = 1'b1;
        tick();
        t_rst = 1'b0;
        check("rh_req", pipe_flush_req, 1'b0);
        check("rh_ack", src_ack, 3'b000);
        serve(1);
        check("rh_reack", src_ack, 3'b010);
        tick();

        // counter saturation at the 2-bit maximum
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_src(0, 32'h100 + k, 32'h4, 1'b0);
            serve(1);
            check("sat_cnt", flush_cnt, (k < 3) ? k + 1 : 3);
            tick();
        end

        // randomized traffic with responsive sources
        for (int c = 0; c < 3000; c++) begin
            for (int j = 0; j < N; j++) begin
                if (!t_req[j] && $urandom_range(3, 0) == 0)
                    set_src(j, $urandom, $urandom, 1'($urandom_range(1, 0)));
                else if (t_req[j] && $urandom_range(60, 0) == 0)
                    t_req[j] = 1'b0;
            end
            t_ack = ($urandom_range(2, 0) == 0);
            t_rst = ($urandom_range(200, 0) == 0);
            tick();
            t_req = t_req & ~e_ack;
        end
        t_rst = 1'b0;
        t_ack = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
